// File: rtl/sub_sched_pkg.sv
// Shared types and constants for the sub_input_scheduler block.
package sub_sched_pkg;

    localparam int unsigned SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sub_input_scheduler_if.sv
// FIFO-read and pixel-pair output bundle between the scheduler and its neighbours.
interface sub_input_scheduler_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic                  a_empty;
    logic [DATA_WIDTH-1:0] a_dout;
    logic                  a_rd_en;
    logic                  b_empty;
    logic [DATA_WIDTH-1:0] b_dout;
    logic                  b_rd_en;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_a;
    logic [DATA_WIDTH-1:0] out_b;
    logic                  out_last;

    modport master (
        input  a_empty, a_dout, b_empty, b_dout, out_ready,
        output a_rd_en, b_rd_en, out_valid, out_a, out_b, out_last
    );

    modport slave (
        output a_empty, a_dout, b_empty, b_dout, out_ready,
        input  a_rd_en, b_rd_en, out_valid, out_a, out_b, out_last
    );
endinterface

// File: rtl/sub_sched_skid.sv
// Small circular skid buffer absorbing FIFO read latency ahead of the output handshake.
module sub_sched_skid
    import sub_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 17
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int unsigned PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(SKID_DEPTH + 1);

    logic [WIDTH-1:0] mem [SKID_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(SKID_DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/sub_input_scheduler.sv
// Reads paired greyscale/background pixels from two FIFOs and streams one frame to the subtractor.
// Optional feature: define SUB_SCHED_STALL_CNT_EN to add the stall_cycles counter output.
module sub_input_scheduler
    import sub_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = 720,
    parameter int unsigned IMG_HEIGHT = 540
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
`ifdef SUB_SCHED_STALL_CNT_EN
    output logic [31:0] stall_cycles,
`endif
    sub_input_scheduler_if.master bus
);
    localparam int unsigned FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned CNT_W        = $clog2(FRAME_PIXELS + 1);
    localparam int unsigned SKID_W       = DATA_WIDTH * 2 + 1;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] issued;
    logic             rd_c;
    logic             inflight;
    logic             inflight_last;
    logic             pop;
    logic             credit;
    logic             fifos_ready;
    logic             have_work;
    logic             skid_full;
    logic             skid_empty;
    logic [1:0]       occ;
    logic [SKID_W-1:0] skid_head;

    assign fifos_ready = !bus.a_empty && !bus.b_empty;
    assign have_work   = (issued < CNT_W'(FRAME_PIXELS));
    assign occ         = skid_full ? 2'd2 : (skid_empty ? 2'd0 : 2'd1);
    assign pop         = !skid_empty && bus.out_ready;
    // occupancy + in-flight - pop < depth, rearranged to avoid unsigned underflow
    assign credit      = (3'(occ) + 3'(inflight)) < (3'(SKID_DEPTH) + 3'(pop));

    // Next-state and read-issue decode
    always_comb begin
        state_next = state;
        rd_c       = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_next = ST_RUN;
            ST_RUN: begin
                rd_c = fifos_ready && have_work && credit;
                if ((rd_c && issued == CNT_W'(FRAME_PIXELS - 1)) || !have_work)
                    state_next = ST_DRAIN;
            end
            ST_DRAIN: if (!inflight && skid_empty) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            busy       <= (state_next != ST_IDLE);
            frame_done <= (state_next == ST_DONE);
        end
    end

    // Issue counter plus a one-cycle marker for data returning from the registered FIFOs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issued        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) issued <= '0;
            else if (rd_c)                 issued <= issued + CNT_W'(1);
            inflight      <= rd_c;
            inflight_last <= rd_c && (issued == CNT_W'(FRAME_PIXELS - 1));
        end
    end

    assign bus.a_rd_en = rd_c;
    assign bus.b_rd_en = rd_c;

    sub_sched_skid #(.WIDTH(SKID_W)) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_data ({inflight_last, bus.a_dout, bus.b_dout}),
        .pop       (pop),
        .full      (skid_full),
        .empty     (skid_empty),
        .head      (skid_head)
    );

    assign bus.out_valid = !skid_empty;
    assign {bus.out_last, bus.out_a, bus.out_b} = skid_head;

`ifdef SUB_SCHED_STALL_CNT_EN
    // Cycles where the output side could accept more but a FIFO had nothing to give
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if (state == ST_IDLE && start) begin
            stall_cycles <= '0;
        end else if (state == ST_RUN && credit && !fifos_ready && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: doc/sub_input_scheduler.md
SUB_INPUT_SCHEDULER -- requirements
Module: sub_input_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width of both FIFO streams.
REQ-002 SHALL have parameter IMG_WIDTH, default 720, pixels per line.
REQ-003 SHALL have parameter IMG_HEIGHT, default 540, lines per frame; FRAME_PIXELS = IMG_WIDTH*IMG_HEIGHT.
REQ-004 SHALL have ports: clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: start  in  1  frame-start request; a_empty  in  1  greyscale FIFO empty.
REQ-007 SHALL have ports: a_dout  in  DATA_WIDTH  greyscale FIFO data; a_rd_en  out  1  greyscale FIFO read.
REQ-008 SHALL have ports: b_empty  in  1  background FIFO empty; b_dout  in  DATA_WIDTH  background data; b_rd_en  out  1  background read.
REQ-009 SHALL have ports: out_valid  out  1; out_ready  in  1; out_a, out_b  out  DATA_WIDTH  pixel pair to subtractor; out_last  out  1  final pixel of frame.
REQ-010 SHALL have ports: busy  out  1  frame in progress; frame_done  out  1  one-cycle completion pulse.

Function
REQ-011 SHALL implement FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
REQ-012 IDLE: start=1 -> RUN next cycle, issue counter cleared; start ignored in every other state.
REQ-013 RUN: a_rd_en and b_rd_en SHALL always be identical; asserted only when a_empty=0, b_empty=0, issued<FRAME_PIXELS, credit available.
REQ-014 Credit: skid occupancy + reads in flight - pop this cycle < 2; pop = out_valid & out_ready.
REQ-015 FIFO data SHALL be captured exactly one cycle after rd_en (registered FIFO output) and pushed into 2-entry skid buffer.
REQ-016 Sustained throughput SHALL be 1 pixel/cycle when both FIFOs non-empty and out_ready held high.
REQ-017 issued reaches FRAME_PIXELS -> DRAIN; DRAIN -> DONE when no read in flight and skid empty.
REQ-018 DONE: frame_done=1 for exactly one cycle, then IDLE.
REQ-019 out_last=1 with the FRAME_PIXELS-th pair only; out_a/out_b/out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 busy=1 in RUN, DRAIN, DONE; 0 in IDLE.
REQ-021 Issue counter width $clog2(FRAME_PIXELS+1); no wrap within a frame.
REQ-022 One FIFO empty while other not: no read on either; no data lost or reordered.

Reset
REQ-023 reset_n=0 at any time (incl. mid-frame) SHALL force IDLE, clear counters and skid, and drive a_rd_en, b_rd_en, out_valid, out_last, busy, frame_done to 0, out_a/out_b to 0.
REQ-024 First start SHALL be accepted the first clock edge after reset_n deasserts.

Configuration
REQ-025 Macro SUB_SCHED_STALL_CNT_EN defined: output stall_cycles (32 bit) counts RUN cycles with credit available but either FIFO empty; cleared on start and reset; saturates at all-ones.
REQ-026 Macro undefined: no stall_cycles port, no counter logic; all other behaviour identical.

Structure
REQ-027 Package sub_sched_pkg SHALL hold the state enum typedef and skid depth constant (2).
REQ-028 The skid buffer SHALL be sub-module sub_sched_skid (push/pop/full/empty, parameter DATA_WIDTH*2+1).

Verification (IMG_WIDTH=4, IMG_HEIGHT=2, FRAME_PIXELS=8)
REQ-029 Both FIFOs preloaded 8 words, out_ready=1, start pulse -> 8 rd_en cycles back-to-back, 8 consecutive out_valid pairs, out_last on 8th, frame_done one cycle after DRAIN completes.
REQ-030 out_ready toggled 1/0 each cycle -> no pair lost or duplicated, outputs stable while stalled, rd_en never exceeds credit.
REQ-031 b_empty held 1 for 5 cycles mid-frame with a non-empty -> a_rd_en=0 throughout; sequence resumes in order; stall_cycles=5 with macro.
REQ-032 reset_n pulsed low after 3 pairs -> all outputs 0, IDLE; new start streams full 8 pixels from FIFO head.
REQ-033 start asserted during RUN and DONE -> ignored; exactly one frame_done per accepted start.
